icache_arbiter: RTL and testbench

ICACHE_ARBITER -- requirements
Module: icache_arbiter

---
 rtl/cpu_types_pkg.sv | 9 +
 rtl/icache_arbiter.sv | 82 ++++++++
 tb/tb_icache_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types; ramstate_t reports the status of the shared RAM port.
package cpu_types_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

// File: rtl/icache_arbiter.sv
// Round-robin arbiter sharing one RAM read port between two core icaches.
// state | meaning
// IDLE  | no access in flight; arbitrate among iREN at the next edge
// SERVE | RAM port owned by core `grant` until ACCESS or abort
module icache_arbiter
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic [1:0]  iREN,
  input  logic [31:0] iaddr0,
  input  logic [31:0] iaddr1,
  output logic [1:0]  iwait,
  output logic [31:0] iload0,
  output logic [31:0] iload1,
  output logic        ramREN,
  output logic [31:0] ramaddr,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate
);

  typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_t;

  state_t state, state_next;
  logic   grant, grant_next;
  logic   ptr, ptr_next;
  logic   active, done;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      grant <= 1'b0;
      ptr   <= 1'b0;
    end else begin
      state <= state_next;
      grant <= grant_next;
      ptr   <= ptr_next;
    end
  end

  assign active = (state == SERVE) && iREN[grant];
  assign done   = active && (ramstate == ACCESS);

  always_comb begin
    state_next = state;
    grant_next = grant;
    ptr_next   = ptr;
    case (state)
      IDLE: begin
        if (iREN != 2'b00) begin
          state_next = SERVE;
          grant_next = (iREN == 2'b11) ? ptr : iREN[1];
        end
      end
      SERVE: begin
        // Completion always passes through IDLE so a still-asserted iREN is not regranted.
        if (!iREN[grant]) begin
          state_next = IDLE;
        end else if (done) begin
          state_next = IDLE;
          ptr_next   = ~grant;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ramREN  = active;
    ramaddr = 32'h0;
    iload0  = 32'h0;
    iload1  = 32'h0;
    iwait   = 2'b11;
    if (state == SERVE) begin
      ramaddr = grant ? iaddr1 : iaddr0;
      if (grant) iload1 = ramload;
      else       iload0 = ramload;
    end
    if (done) iwait[grant] = 1'b0;
  end

endmodule

// File: tb/tb_icache_arbiter.sv
// Directed bench for icache_arbiter; expected outputs are queued per step and popped at the sample point.
module tb_icache_arbiter;
  import cpu_types_pkg::*;

  logic        CLK;
  logic        nRST;
  logic [1:0]  iREN;
  logic [31:0] iaddr0, iaddr1;
  logic [1:0]  iwait;
  logic [31:0] iload0, iload1;
  logic        ramREN;
  logic [31:0] ramaddr;
  logic [31:0] ramload;
  ramstate_t   ramstate;

  int total = 0;
  int bad   = 0;
  logic ptr_m;

  typedef struct {
    string       tag;
    logic [1:0]  w;
    logic        ren;
    logic [31:0] addr;
    logic [31:0] l0;
    logic [31:0] l1;
  } exp_t;

  exp_t sb[$];

  icache_arbiter dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr0(iaddr0), .iaddr1(iaddr1),
    .iwait(iwait), .iload0(iload0), .iload1(iload1), .ramREN(ramREN),
    .ramaddr(ramaddr), .ramload(ramload), .ramstate(ramstate)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic push_exp(input string tag, input logic [1:0] w, input logic ren,
                          input logic [31:0] addr, input logic [31:0] l0, input logic [31:0] l1);
    exp_t e;
    e.tag = tag; e.w = w; e.ren = ren; e.addr = addr; e.l0 = l0; e.l1 = l1;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL scoreboard_empty got=0 exp=1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      total++;
      assert (iwait === e.w) else begin
        bad++; $error("FAIL %s iwait got=%b exp=%b", e.tag, iwait, e.w);
      end
      total++;
      assert (ramREN === e.ren) else begin
        bad++; $error("FAIL %s ramREN got=%b exp=%b", e.tag, ramREN, e.ren);
      end
      total++;
      assert (ramaddr === e.addr) else begin
        bad++; $error("FAIL %s ramaddr got=%h exp=%h", e.tag, ramaddr, e.addr);
      end
      total++;
      assert (iload0 === e.l0) else begin
        bad++; $error("FAIL %s iload0 got=%h exp=%h", e.tag, iload0, e.l0);
      end
      total++;
      assert (iload1 === e.l1) else begin
        bad++; $error("FAIL %s iload1 got=%h exp=%h", e.tag, iload1, e.l1);
      end
    end
  endtask

  // Drive just after a rising edge, sample mid-cycle, then advance to the next edge.
  task automatic step(input string tag, input logic [1:0] ren_in, input logic [31:0] a0,
                      input logic [31:0] a1, input ramstate_t rs, input logic [31:0] rl,
                      input logic [1:0] ew, input logic eren, input logic [31:0] eaddr,
                      input logic [31:0] el0, input logic [31:0] el1);
    iREN = ren_in; iaddr0 = a0; iaddr1 = a1; ramstate = rs; ramload = rl;
    push_exp(tag, ew, eren, eaddr, el0, el1);
    #4;
    check_out();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    iREN = 2'b11; iaddr0 = 32'h1; iaddr1 = 32'h2; ramstate = ACCESS; ramload = 32'hFFFF_FFFF;
    push_exp("reset", 2'b11, 1'b0, 32'h0, 32'h0, 32'h0);
    #4;
    check_out();
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b0; iREN = 2'b00; iaddr0 = 32'h0; iaddr1 = 32'h0;
    ramstate = FREE; ramload = 32'h0;
    #1;
    do_reset();

    // Single requester, BUSY twice then ACCESS.
    step("single_idle",  2'b01, 32'h40, 32'h0, BUSY,   32'h1111_1111, 2'b11, 1'b0, 32'h0,  32'h0, 32'h0);
    step("single_busy1", 2'b01, 32'h40, 32'h0, BUSY,   32'h1111_1111, 2'b11, 1'b1, 32'h40, 32'h1111_1111, 32'h0);
    step("single_busy2", 2'b01, 32'h40, 32'h0, BUSY,   32'h1111_1111, 2'b11, 1'b1, 32'h40, 32'h1111_1111, 32'h0);
    step("single_acc",   2'b01, 32'h40, 32'h0, ACCESS, 32'hDEAD_BEEF, 2'b10, 1'b1, 32'h40, 32'hDEAD_BEEF, 32'h0);
    step("single_after", 2'b00, 32'h40, 32'h0, FREE,   32'h0,         2'b11, 1'b0, 32'h0,  32'h0, 32'h0);

    do_reset();

    // Both request after reset: core 0 first, IDLE bubble, then core 1.
    step("both_idle0", 2'b11, 32'h100, 32'h200, ACCESS, 32'hA0A0_A0A0, 2'b11, 1'b0, 32'h0,   32'h0, 32'h0);
    step("both_srv0",  2'b11, 32'h100, 32'h200, ACCESS, 32'hA0A0_A0A0, 2'b10, 1'b1, 32'h100, 32'hA0A0_A0A0, 32'h0);
    step("both_idle1", 2'b11, 32'h100, 32'h200, ACCESS, 32'hB0B0_B0B0, 2'b11, 1'b0, 32'h0,   32'h0, 32'h0);
    step("both_srv1",  2'b11, 32'h100, 32'h200, ACCESS, 32'hB0B0_B0B0, 2'b01, 1'b1, 32'h200, 32'h0, 32'hB0B0_B0B0);

    // Fairness over six back-to-back accesses with both cores requesting.
    ptr_m = 1'b0;
    for (int k = 0; k < 6; k++) begin
      logic [31:0] a0, a1, rl;
      a0 = 32'h1000 + k; a1 = 32'h2000 + k; rl = 32'hC000_0000 | k;
      step("fair_idle", 2'b11, a0, a1, ACCESS, rl, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0);
      if (ptr_m == 1'b0)
        step("fair_srv_c0", 2'b11, a0, a1, ACCESS, rl, 2'b10, 1'b1, a0, rl, 32'h0);
      else
        step("fair_srv_c1", 2'b11, a0, a1, ACCESS, rl, 2'b01, 1'b1, a1, 32'h0, rl);
      ptr_m = ~ptr_m;
    end

    // Move pointer to 1, then abort a core 1 access; pointer must stay 1.
    step("ab_idle0",  2'b01, 32'h400, 32'h300, ACCESS, 32'h4,   2'b11, 1'b0, 32'h0,   32'h0, 32'h0);
    step("ab_srv0",   2'b01, 32'h400, 32'h300, ACCESS, 32'h4,   2'b10, 1'b1, 32'h400, 32'h4, 32'h0);
    step("ab_idle1",  2'b10, 32'h400, 32'h300, BUSY,   32'h5,   2'b11, 1'b0, 32'h0,   32'h0, 32'h0);
    step("ab_busy",   2'b10, 32'h400, 32'h300, BUSY,   32'h5,   2'b11, 1'b1, 32'h300, 32'h0, 32'h5);
    step("ab_drop",   2'b00, 32'h400, 32'h300, BUSY,   32'h5,   2'b11, 1'b0, 32'h300, 32'h0, 32'h5);
    step("ab_bubble", 2'b11, 32'h400, 32'h300, ACCESS, 32'h6,   2'b11, 1'b0, 32'h0,   32'h0, 32'h0);
    step("ab_ptr1",   2'b11, 32'h400, 32'h300, ACCESS, 32'h6,   2'b01, 1'b1, 32'h300, 32'h0, 32'h6);

    // Pointer to 1, ERROR holds core 1, reset mid-SERVE, then core 0 wins a tie.
    step("er_idle0", 2'b01, 32'h600, 32'h700, ACCESS, 32'h8, 2'b11, 1'b0, 32'h0,   32'h0, 32'h0);
    step("er_srv0",  2'b01, 32'h600, 32'h700, ACCESS, 32'h8, 2'b10, 1'b1, 32'h600, 32'h8, 32'h0);
    step("er_idle1", 2'b10, 32'h600, 32'h700, ERROR,  32'h9, 2'b11, 1'b0, 32'h0,   32'h0, 32'h0);
    for (int k = 0; k < 3; k++)
      step("er_hold", 2'b10, 32'h600, 32'h700, ERROR, 32'h9, 2'b11, 1'b1, 32'h700, 32'h0, 32'h9);

    iREN = 2'b10; ramstate = ACCESS; ramload = 32'h9;
    #1;
    nRST = 1'b0;
    push_exp("rst_mid", 2'b11, 1'b0, 32'h0, 32'h0, 32'h0);
    #3;
    check_out();
    @(posedge CLK);
    #1;
    push_exp("rst_held", 2'b11, 1'b0, 32'h0, 32'h0, 32'h0);
    #4;
    check_out();
    @(posedge CLK);
    #1;
    nRST = 1'b1;

    step("post_idle", 2'b11, 32'h800, 32'h900, ACCESS, 32'hA, 2'b11, 1'b0, 32'h0,   32'h0, 32'h0);
    step("post_ptr0", 2'b11, 32'h800, 32'h900, ACCESS, 32'hA, 2'b10, 1'b1, 32'h800, 32'hA, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
